// File: rtl/operand_pkg.sv
// rtl/operand_pkg.sv - shared types and defaults for the operand pair FIFO
package operand_pkg;

    typedef struct packed {
        int a;
        int b;
    } operand_pair_t;

    localparam int OPERAND_FIFO_DEPTH = 4;

endpackage

// File: rtl/operand_fifo_ptr.sv
// rtl/operand_fifo_ptr.sv - read/write pointers and occupancy count of the operand pair FIFO
module operand_fifo_ptr
    import operand_pkg::*;
#(
    parameter int DEPTH = OPERAND_FIFO_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    output logic [PW-1:0] rd_ptr,
    output logic [PW-1:0] wr_ptr,
    output logic [CW-1:0] count
);

    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] wr_ptr_nxt;

    // Successor pointers, wrapping from the last entry back to 0
    always_comb begin
        rd_ptr_nxt = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
        wr_ptr_nxt = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
    end

    // Pointer and count state; flush wins over any same-cycle push or pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_pair_fifo.sv
// rtl/operand_pair_fifo.sv - operand pair buffer feeding the adder stage over valid/ready
module operand_pair_fifo
    import operand_pkg::*;
#(
    parameter int DEPTH = OPERAND_FIFO_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_valid,
    input  int            i_a,
    input  int            i_b,
    output logic          o_ready,
    output logic          o_valid,
    output int            o_opa,
    output int            o_opb,
    input  logic          i_ready,
    output logic [CW-1:0] o_count,
    output logic          o_drop
);

    operand_pair_t mem [DEPTH];
    operand_pair_t wr_pair;
    operand_pair_t head_pair;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Handshake decode from registered occupancy only
    always_comb begin
        o_ready   = (count != CW'(DEPTH));
        o_valid   = (count != '0);
        push      = i_valid && o_ready;
        pop       = o_valid && i_ready;
        wr_pair.a = i_a;
        wr_pair.b = i_b;
        head_pair = mem[rd_ptr];
        o_opa     = head_pair.a;
        o_opb     = head_pair.b;
        o_count   = count;
    end

    operand_fifo_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (i_flush),
        .rd_ptr  (rd_ptr),
        .wr_ptr  (wr_ptr),
        .count   (count)
    );

    // Pair storage; cleared on reset so an idle head reads as zero, untouched by flush
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !i_flush) begin
            mem[wr_ptr] <= wr_pair;
        end
    end

    // Registered drop pulse for an offer refused because the FIFO was full
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drop <= 1'b0;
        end else if (i_flush) begin
            o_drop <= 1'b0;
        end else begin
            o_drop <= i_valid && !o_ready;
        end
    end

endmodule

// File: tb/tb_operand_pair_fifo.sv
// tb/tb_operand_pair_fifo.sv - self-checking bench for operand_pair_fifo against a queue model
module tb_operand_pair_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_flush;
    logic          i_valid;
    int            i_a;
    int            i_b;
    logic          o_ready;
    logic          o_valid;
    int            o_opa;
    int            o_opb;
    logic          i_ready;
    logic [CW-1:0] o_count;
    logic          o_drop;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] q [$];
    bit          m_drop;

    always #5 i_clk = ~i_clk;

    operand_pair_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_opa   (o_opa),
        .o_opb   (o_opb),
        .i_ready (i_ready),
        .o_count (o_count),
        .o_drop  (o_drop)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count", 64'(o_count), 64'(q.size()));
        chk("valid", 64'(o_valid), 64'(q.size() != 0));
        chk("ready", 64'(o_ready), 64'(q.size() != DEPTH));
        chk("drop",  64'(o_drop),  64'(m_drop));
        if (q.size() != 0) begin
            chk("opa", {32'h0, o_opa}, {32'h0, q[0][63:32]});
            chk("opb", {32'h0, o_opb}, {32'h0, q[0][31:0]});
        end
    endtask

    // One clock: drive inputs, let the edge pass, advance the model, compare
    task automatic cyc(input bit v, input int a, input int b, input bit r, input bit f);
        bit full;
        bit empty;
        i_valid = v;
        i_a     = a;
        i_b     = b;
        i_ready = r;
        i_flush = f;
        @(posedge i_clk);
        if (f) begin
            q.delete();
            m_drop = 1'b0;
        end else begin
            full   = (q.size() == DEPTH);
            empty  = (q.size() == 0);
            m_drop = v && full;
            if (r && !empty) void'(q.pop_front());
            if (v && !full)  q.push_back({a, b});
        end
        #1;
        check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 64'(o_count), 64'd0);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_ready"}, 64'(o_ready), 64'd1);
        chk({tag, "_drop"},  64'(o_drop),  64'd0);
        chk({tag, "_opa"},   {32'h0, o_opa}, 64'd0);
        chk({tag, "_opb"},   {32'h0, o_opb}, 64'd0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = 0;
        i_b     = 0;
        m_drop  = 1'b0;
        #1;
        check_reset_state("rst0");
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Fill and drain, with a refused fifth offer
        cyc(1, 1, 2, 0, 0);
        cyc(1, 3, 4, 0, 0);
        cyc(1, 5, 6, 0, 0);
        cyc(1, 7, 8, 0, 0);
        chk("fill_count4", 64'(o_count), 64'd4);
        cyc(1, 9, 10, 0, 0);
        chk("fill_drop", 64'(o_drop), 64'd1);
        cyc(0, 0, 0, 0, 0);
        chk("fill_drop_clear", 64'(o_drop), 64'd0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);

        // Streaming across pointer wrap, pairs (k, -k)
        for (int k = 0; k < 12; k++) cyc(1, k, -k, 1, 0);
        chk("stream_count", 64'(o_count), 64'd1);
        cyc(0, 0, 0, 1, 0);

        // Full with simultaneous offer and pop
        for (int i = 0; i < 4; i++) cyc(1, 40 + i, 50 + i, 0, 0);
        cyc(1, 100, 200, 1, 0);
        chk("fullpop_count", 64'(o_count), 64'd3);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);

        // Flush priority over same-cycle push and pop
        cyc(1, 1, 1, 0, 0);
        cyc(1, 2, 2, 0, 0);
        cyc(1, 5, 5, 1, 1);
        chk("flush_count", 64'(o_count), 64'd0);
        cyc(1, 11, 22, 0, 0);
        chk("flush_head", {32'h0, o_opa, o_opb} >> 0, {32'd11, 32'd22});
        cyc(0, 0, 0, 1, 0);

        // Extreme operand values
        cyc(1, 32'h7FFFFFFF, 32'h80000000, 0, 0);
        chk("extreme_opa", {32'h0, o_opa}, 64'h7FFFFFFF);
        chk("extreme_opb", {32'h0, o_opb}, 64'h80000000);
        cyc(0, 0, 0, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom), int'($urandom),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset with three entries held
        cyc(1, 0, 0, 0, 1);
        cyc(1, 31, 32, 0, 0);
        cyc(1, 33, 34, 0, 0);
        cyc(1, 35, 36, 0, 0);
        i_valid = 1'b0;
        i_ready = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        q.delete();
        m_drop = 1'b0;
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        cyc(1, 7, 9, 0, 0);
        chk("rst_first_opa", {32'h0, o_opa}, 64'd7);
        chk("rst_first_opb", {32'h0, o_opb}, 64'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
